// File: rtl/f_to_d_queue_if.sv
// Fetch-to-decode queue bundle: fetch-side entry, pipeline hold/redirect controls, head entry and occupancy.
// With FDQ_PERF_EN defined the bundle also carries the two performance counters.
interface f_to_d_queue_if #(
  parameter int XLEN     = 32,
  parameter int VPC_BITS = 32,
  parameter int DEPTH    = 4
) ();
  // Handshake: fetch offers an entry with F_valid and must hold it until a cycle in which F_ready is high
  // and neither Itlb_stall nor EX_taken is set; decode consumes the head when D_valid is high and neither
  // stall_D, MEM_stall nor EX_taken is set.
  logic                  F_valid;
  logic                  F_BP_taken;
  logic [VPC_BITS-1:0]   F_pc;
  logic [VPC_BITS-1:0]   F_BP_target_pc;
  logic [XLEN-1:0]       F_inst;
  logic                  F_ready;
  logic                  stall_D;
  logic                  MEM_stall;
  logic                  Itlb_stall;
  logic                  EX_taken;
  logic                  D_valid;
  logic [VPC_BITS-1:0]   D_pc;
  logic [VPC_BITS-1:0]   D_BP_target_pc;
  logic [XLEN-1:0]       D_inst;
  logic                  D_BP_taken;
  logic [$clog2(DEPTH):0] count;
`ifdef FDQ_PERF_EN
  logic [31:0]           perf_flush_cnt;
  logic [31:0]           perf_full_cnt;
`endif

  modport master (
    output F_valid, F_BP_taken, F_pc, F_BP_target_pc, F_inst,
    output stall_D, MEM_stall, Itlb_stall, EX_taken,
    input  F_ready, D_valid, D_pc, D_BP_target_pc, D_inst, D_BP_taken, count
`ifdef FDQ_PERF_EN
    , input perf_flush_cnt, perf_full_cnt
`endif
  );

  modport slave (
    input  F_valid, F_BP_taken, F_pc, F_BP_target_pc, F_inst,
    input  stall_D, MEM_stall, Itlb_stall, EX_taken,
    output F_ready, D_valid, D_pc, D_BP_target_pc, D_inst, D_BP_taken, count
`ifdef FDQ_PERF_EN
    , output perf_flush_cnt, perf_full_cnt
`endif
  );
endinterface

// File: rtl/f_to_d_queue.sv
// Circular fetch-to-decode queue with 1-cycle minimum latency and flush on redirect.
// Optional FDQ_PERF_EN adds flush and full-with-valid event counters.
module f_to_d_queue #(
  parameter int XLEN     = 32,
  parameter int VPC_BITS = 32,
  parameter int DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  f_to_d_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP32 = 32'h2000_0000;

  typedef struct packed {
    logic [VPC_BITS-1:0] pc;
    logic [XLEN-1:0]     inst;
    logic                bp_taken;
    logic [VPC_BITS-1:0] target;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            f_ready;
  logic            full;
  logic            d_valid;
  logic            enq;
  logic            deq;
  entry_t          head;

  assign full    = (count_q == CW'(DEPTH));
  assign f_ready = !full;
  assign d_valid = (count_q != '0);
  assign enq     = q.F_valid & f_ready & !q.Itlb_stall & !q.EX_taken;
  assign deq     = d_valid & !q.stall_D & !q.MEM_stall & !q.EX_taken;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (q.EX_taken) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      mem_q[wr_ptr_q] <= '{pc: q.F_pc, inst: q.F_inst, bp_taken: q.F_BP_taken,
                           target: q.F_BP_target_pc};
    end
  end

  assign head             = mem_q[rd_ptr_q];
  assign q.F_ready        = f_ready;
  assign q.count          = count_q;
  assign q.D_valid        = d_valid;
  assign q.D_pc           = d_valid ? head.pc       : '0;
  assign q.D_inst         = d_valid ? head.inst     : XLEN'(NOP32);
  assign q.D_BP_taken     = d_valid ? head.bp_taken : 1'b0;
  assign q.D_BP_target_pc = d_valid ? head.target   : '0;

`ifdef FDQ_PERF_EN
  logic [31:0] perf_flush_q;
  logic [31:0] perf_full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_flush_q <= '0;
      perf_full_q  <= '0;
    end else begin
      if (q.EX_taken && d_valid) perf_flush_q <= perf_flush_q + 32'd1;
      if (full && q.F_valid)     perf_full_q  <= perf_full_q + 32'd1;
    end
  end

  assign q.perf_flush_cnt = perf_flush_q;
  assign q.perf_full_cnt  = perf_full_q;
`endif
endmodule

// File: tb/tb_f_to_d_queue.sv
// Directed bench for f_to_d_queue: reset, basic flow, fill, flush, Itlb block, wrap with toggling
// MEM_stall and (with FDQ_PERF_EN) the performance counters.
module tb_f_to_d_queue;
  localparam int XLEN     = 32;
  localparam int VPC_BITS = 32;
  localparam int DEPTH    = 4;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int HW       = 2 * VPC_BITS + XLEN + 2;
  localparam logic [XLEN-1:0] NOP = 32'h2000_0000;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  f_to_d_queue_if #(.XLEN(XLEN), .VPC_BITS(VPC_BITS), .DEPTH(DEPTH)) bus ();
  f_to_d_queue #(.XLEN(XLEN), .VPC_BITS(VPC_BITS), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .q  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] inst_of(input logic [VPC_BITS-1:0] pc);
    return {pc[15:0], 16'hC0DE};
  endfunction

  // Expected head vector {valid, pc, inst, bp_taken, target} for an entry driven with drive_f(1, pc).
  function automatic logic [HW-1:0] head_exp(input logic [VPC_BITS-1:0] pc);
    return {1'b1, pc, inst_of(pc), pc[2], pc + 32'h40};
  endfunction

  function automatic logic [HW-1:0] head_empty();
    return {1'b0, {VPC_BITS{1'b0}}, NOP, 1'b0, {VPC_BITS{1'b0}}};
  endfunction

  function automatic logic [HW-1:0] head_obs();
    return {bus.D_valid, bus.D_pc, bus.D_inst, bus.D_BP_taken, bus.D_BP_target_pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.F_valid = 1'b0; bus.F_BP_taken = 1'b0; bus.F_pc = '0; bus.F_BP_target_pc = '0;
    bus.F_inst = '0; bus.stall_D = 1'b0; bus.MEM_stall = 1'b0; bus.Itlb_stall = 1'b0;
    bus.EX_taken = 1'b0;
  endtask

  task automatic drive_f(input logic v, input logic [VPC_BITS-1:0] pc);
    bus.F_valid        = v;
    bus.F_pc           = pc;
    bus.F_inst         = inst_of(pc);
    bus.F_BP_taken     = pc[2];
    bus.F_BP_target_pc = pc + 32'h40;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.F_ready !== 1'b1) begin bad++; $display("FAIL reset_f_ready got=%b exp=1", bus.F_ready); end
    total++; if (head_obs() !== head_empty()) begin bad++; $display("FAIL reset_head got=%h exp=%h", head_obs(), head_empty()); end
    // Mid-operation reset discards queued entries.
    bus.stall_D = 1'b1;
    drive_f(1'b1, 32'h80); step();
    drive_f(1'b1, 32'h84); step();
    drive_f(1'b0, 32'h0);
    total++; if (bus.count !== CW'(2)) begin bad++; $display("FAIL pre_rst_count got=%0d exp=2", bus.count); end
    rst = 1'b1; step(); rst = 1'b0;
    bus.stall_D = 1'b0;
    total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", bus.count); end
    total++; if (head_obs() !== head_empty()) begin bad++; $display("FAIL mid_rst_head got=%h exp=%h", head_obs(), head_empty()); end
  endtask

  task automatic test_basic();
    idle_inputs();
    drive_f(1'b1, 32'h100);
    total++; if (bus.D_valid !== 1'b0) begin bad++; $display("FAIL basic_no_bypass got=%b exp=0", bus.D_valid); end
    for (int i = 0; i < 4; i++) begin
      drive_f(1'b1, 32'h100 + 32'(4 * i));
      step();
      total++; if (bus.count !== CW'(1)) begin bad++; $display("FAIL basic_count%0d got=%0d exp=1", i, bus.count); end
      total++; if (head_obs() !== head_exp(32'h100 + 32'(4 * i))) begin
        bad++; $display("FAIL basic_head%0d got=%h exp=%h", i, head_obs(), head_exp(32'h100 + 32'(4 * i)));
      end
    end
    drive_f(1'b0, 32'h0);
    step();
    total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL basic_drain_count got=%0d exp=0", bus.count); end
    total++; if (head_obs() !== head_empty()) begin bad++; $display("FAIL basic_drain_head got=%h exp=%h", head_obs(), head_empty()); end
  endtask

  task automatic test_fill();
    idle_inputs();
    bus.stall_D = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_f(1'b1, 32'h200 + 32'(4 * i));
      step();
    end
    drive_f(1'b1, 32'h210);
    total++; if (bus.count !== CW'(4)) begin bad++; $display("FAIL fill_count got=%0d exp=4", bus.count); end
    total++; if (bus.F_ready !== 1'b0) begin bad++; $display("FAIL fill_f_ready got=%b exp=0", bus.F_ready); end
    total++; if (head_obs() !== head_exp(32'h200)) begin bad++; $display("FAIL fill_head got=%h exp=%h", head_obs(), head_exp(32'h200)); end
    step();
    total++; if (bus.count !== CW'(4)) begin bad++; $display("FAIL fill_hold_count got=%0d exp=4", bus.count); end
    total++; if (head_obs() !== head_exp(32'h200)) begin bad++; $display("FAIL fill_hold_head got=%h exp=%h", head_obs(), head_exp(32'h200)); end
    bus.stall_D = 1'b0;
    step();
    total++; if (bus.count !== CW'(3)) begin bad++; $display("FAIL fill_rel_count got=%0d exp=3", bus.count); end
    total++; if (head_obs() !== head_exp(32'h204)) begin bad++; $display("FAIL fill_rel_head got=%h exp=%h", head_obs(), head_exp(32'h204)); end
    step();
    total++; if (bus.count !== CW'(3)) begin bad++; $display("FAIL fill_5th_count got=%0d exp=3", bus.count); end
    total++; if (head_obs() !== head_exp(32'h208)) begin bad++; $display("FAIL fill_5th_head got=%h exp=%h", head_obs(), head_exp(32'h208)); end
    drive_f(1'b0, 32'h0);
    step();
    total++; if (head_obs() !== head_exp(32'h20C)) begin bad++; $display("FAIL fill_d2_head got=%h exp=%h", head_obs(), head_exp(32'h20C)); end
    step();
    total++; if (head_obs() !== head_exp(32'h210)) begin bad++; $display("FAIL fill_d1_head got=%h exp=%h", head_obs(), head_exp(32'h210)); end
    total++; if (bus.count !== CW'(1)) begin bad++; $display("FAIL fill_d1_count got=%0d exp=1", bus.count); end
    step();
    total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL fill_empty_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_flush();
    idle_inputs();
    bus.stall_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_f(1'b1, 32'h300 + 32'(4 * i));
      step();
    end
    total++; if (bus.count !== CW'(3)) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", bus.count); end
    bus.EX_taken = 1'b1;
    bus.stall_D  = 1'b0;
    drive_f(1'b1, 32'h400);
    step();
    total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
    total++; if (head_obs() !== head_empty()) begin bad++; $display("FAIL flush_head got=%h exp=%h", head_obs(), head_empty()); end
    bus.EX_taken = 1'b0;
    drive_f(1'b0, 32'h0);
    step();
    total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL flush_drop_count got=%0d exp=0", bus.count); end
    total++; if (bus.F_ready !== 1'b1) begin bad++; $display("FAIL flush_f_ready got=%b exp=1", bus.F_ready); end
  endtask

  task automatic test_itlb();
    idle_inputs();
    bus.stall_D = 1'b1;
    drive_f(1'b1, 32'h500); step();
    drive_f(1'b1, 32'h504); step();
    bus.Itlb_stall = 1'b1;
    drive_f(1'b1, 32'h508);
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.count !== CW'(2)) begin bad++; $display("FAIL itlb_count%0d got=%0d exp=2", i, bus.count); end
    end
    bus.stall_D = 1'b0;
    step();
    total++; if (bus.count !== CW'(1)) begin bad++; $display("FAIL itlb_deq_count got=%0d exp=1", bus.count); end
    total++; if (head_obs() !== head_exp(32'h504)) begin bad++; $display("FAIL itlb_deq_head got=%h exp=%h", head_obs(), head_exp(32'h504)); end
    bus.Itlb_stall = 1'b0;
    drive_f(1'b0, 32'h0);
    step();
    total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL itlb_empty_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_back_to_back();
    logic [VPC_BITS-1:0] exp_q[$];
    logic [VPC_BITS-1:0] pc;
    int   sent   = 0;
    int   cycles = 0;
    int   sz;
    logic mem_stall = 1'b0;
    idle_inputs();
    while ((sent < 10 || exp_q.size() != 0) && cycles < 80) begin
      total++; if (bus.count !== CW'(exp_q.size())) begin bad++; $display("FAIL b2b_count c%0d got=%0d exp=%0d", cycles, bus.count, exp_q.size()); end
      total++; if (bus.count > CW'(DEPTH)) begin bad++; $display("FAIL b2b_overflow c%0d got=%0d exp<=%0d", cycles, bus.count, DEPTH); end
      if (exp_q.size() > 0) begin
        total++; if (head_obs() !== head_exp(exp_q[0])) begin bad++; $display("FAIL b2b_head c%0d got=%h exp=%h", cycles, head_obs(), head_exp(exp_q[0])); end
      end else begin
        total++; if (head_obs() !== head_empty()) begin bad++; $display("FAIL b2b_empty c%0d got=%h exp=%h", cycles, head_obs(), head_empty()); end
      end
      mem_stall     = ~mem_stall;
      bus.MEM_stall = mem_stall;
      pc = 32'h600 + 32'(4 * sent);
      drive_f(sent < 10, pc);
      sz = exp_q.size();
      if (sz > 0 && !mem_stall) void'(exp_q.pop_front());
      if (sent < 10 && sz < DEPTH) begin
        exp_q.push_back(pc);
        sent++;
      end
      step();
      cycles++;
    end
    total++; if (cycles >= 80) begin bad++; $display("FAIL b2b_timeout got=%0d cycles exp<80", cycles); end
    idle_inputs();
    total++; if (bus.count !== CW'(0)) begin bad++; $display("FAIL b2b_final_count got=%0d exp=0", bus.count); end
  endtask

`ifdef FDQ_PERF_EN
  task automatic test_perf();
    idle_inputs();
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (bus.perf_flush_cnt !== 32'd0) begin bad++; $display("FAIL perf_rst_flush got=%0d exp=0", bus.perf_flush_cnt); end
    total++; if (bus.perf_full_cnt !== 32'd0) begin bad++; $display("FAIL perf_rst_full got=%0d exp=0", bus.perf_full_cnt); end
    bus.stall_D = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_f(1'b1, 32'h700 + 32'(4 * i));
      step();
    end
    drive_f(1'b1, 32'h710);
    step(); step(); step();
    drive_f(1'b0, 32'h0);
    bus.EX_taken = 1'b1; step();
    bus.EX_taken = 1'b0; drive_f(1'b1, 32'h800); step();
    drive_f(1'b0, 32'h0);
    bus.EX_taken = 1'b1; step();
    step();
    bus.EX_taken = 1'b0;
    total++; if (bus.perf_flush_cnt !== 32'd2) begin bad++; $display("FAIL perf_flush got=%0d exp=2", bus.perf_flush_cnt); end
    total++; if (bus.perf_full_cnt !== 32'd3) begin bad++; $display("FAIL perf_full got=%0d exp=3", bus.perf_full_cnt); end
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_flush();
    test_itlb();
    test_back_to_back();
`ifdef FDQ_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
